hci_router_resp_fifo: RTL and testbench

Response-buffering stage placed directly upstream of the reordering router in the HCI interconnect. The router returns responses at a fixed latency of one cycle and ties `r_ready` high, so an initiator that can stall responses cannot be connected to it directly. This block sits between such an initiator and the router. It forwards requests in lock-step across all lanes, stores the router's responses in a small FIFO, and uses credit-based gating of `gnt` so that a response is never dropped.

---
 rtl/hci_router_resp_fifo_if.sv | 40 ++++
 rtl/hci_router_resp_fifo.sv | 119 +++++++++++
 tb/tb_hci_router_resp_fifo.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_router_resp_fifo_if.sv
// HCI core port bundle: request channel, response channel and ECC side signals.
// Modports give the initiator and target views used across the interconnect.
interface hci_core_intf #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned UW = 1,
   parameter int unsigned IW = 1,
   parameter int unsigned EW = 1
);
   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW/8-1:0] be;
   logic [DW-1:0]   data;
   logic [UW-1:0]   user;
   logic [IW-1:0]   id;
   logic [EW-1:0]   ecc;
   logic            ereq;
   logic            egnt;
   logic [DW-1:0]   r_data;
   logic            r_valid;
   logic            r_ready;
   logic [UW-1:0]   r_user;
   logic [IW-1:0]   r_id;
   logic            r_opc;
   logic [EW-1:0]   r_ecc;
   logic            r_evalid;
   logic            r_eready;

   modport initiator (
      output req, add, wen, be, data, user, id, ecc, ereq, r_ready, r_eready,
      input  gnt, egnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, r_evalid
   );

   modport target (
      input  req, add, wen, be, data, user, id, ecc, ereq, r_ready, r_eready,
      output gnt, egnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, r_evalid
   );
endinterface

// File: rtl/hci_router_resp_fifo.sv
// Credit-gated response FIFO ahead of the fixed-latency HCI router; latency 2 (1 with HCI_ROUTER_RESP_FIFO_BYPASS_EN).
// r_ready low holds r_valid/r_data stable; gnt drops once queued plus in-flight responses fill the FIFO.
module hci_router_resp_fifo #(
   parameter int unsigned NB_CHAN = 2,
   parameter int unsigned DW      = 32,
   parameter int unsigned DEPTH   = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   hci_core_intf.target    in  [0:NB_CHAN-1],
   hci_core_intf.initiator out [0:NB_CHAN-1]
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = NB_CHAN * DW;

   logic [CW-1:0]      count_q, count_d;
   logic               infl_q, infl_d;
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]      mem_q [DEPTH];
   logic [LW-1:0]      wr_dat, rd_dat, rsp_dat;
   logic [NB_CHAN-1:0] rdy_vec;
   logic [CW:0]        occ;
   logic               all_rdy, empty, ok, push, pop, rsp_vld;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign all_rdy = &rdy_vec;
   // Pop never frees a credit in the same cycle, keeping r_ready off the gnt path.
   assign occ     = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
   assign ok      = (occ < (CW+1)'(DEPTH));
   assign infl_d  = in[0].req & ok & out[0].gnt;
   assign pop     = ~empty & all_rdy;
   assign rd_dat  = mem_q[rd_ptr_q];

`ifdef HCI_ROUTER_RESP_FIFO_BYPASS_EN
   assign push    = out[0].r_valid & ~(empty & all_rdy);
   assign rsp_vld = empty ? out[0].r_valid : 1'b1;
   assign rsp_dat = empty ? wr_dat : rd_dat;
`else
   assign push    = out[0].r_valid;
   assign rsp_vld = ~empty;
   assign rsp_dat = empty ? '0 : rd_dat;
`endif

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         infl_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear_i) begin
         count_q  <= '0;
         infl_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q <= count_d;
         infl_q  <= infl_d;
         if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !clear_i) mem_q[wr_ptr_q] <= wr_dat;
   end

   for (genvar i = 0; i < NB_CHAN; i++) begin : g_lane
      assign out[i].req      = in[i].req & ok;
      assign out[i].add      = in[i].add;
      assign out[i].wen      = in[i].wen;
      assign out[i].be       = in[i].be;
      assign out[i].data     = in[i].data;
      assign out[i].user     = '0;
      assign out[i].id       = '0;
      assign out[i].ecc      = '0;
      assign out[i].ereq     = 1'b0;
      assign out[i].r_ready  = 1'b1;
      assign out[i].r_eready = 1'b1;

      assign in[i].gnt       = out[0].gnt & ok;
      assign in[i].egnt      = 1'b1;
      assign in[i].r_valid   = rsp_vld;
      assign in[i].r_data    = rsp_dat[i*DW +: DW];
      assign in[i].r_user    = '0;
      assign in[i].r_id      = '0;
      assign in[i].r_opc     = 1'b0;
      assign in[i].r_ecc     = '0;
      assign in[i].r_evalid  = 1'b0;

      assign rdy_vec[i]          = in[i].r_ready;
      assign wr_dat[i*DW +: DW]  = out[i].r_data;
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni && !clear_i) begin
         assert (!(push && (count_q == CW'(DEPTH))))
            else $error("hci_router_resp_fifo: push while full");
      end
   end
`endif

endmodule

// File: tb/tb_hci_router_resp_fifo.sv
// Directed bench: a one-cycle router model behind the FIFO and a scoreboard of expected responses.
module tb_hci_router_resp_fifo;
   localparam int NB_CHAN = 2;
   localparam int DW      = 32;
   localparam int DEPTH   = 3;
`ifdef HCI_ROUTER_RESP_FIFO_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   hci_core_intf #(.DW(DW)) in_if  [0:NB_CHAN-1] ();
   hci_core_intf #(.DW(DW)) out_if [0:NB_CHAN-1] ();

   hci_router_resp_fifo #(.NB_CHAN(NB_CHAN), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clear_i (clear),
      .in      (in_if),
      .out     (out_if)
   );

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      int          t;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          lat_chk = 1'b0;
   logic [31:0] last0 = '0;
   logic [31:0] rmem0 [16];
   logic [31:0] rmem1 [16];
   logic [31:0] emem0 [16];
   logic [31:0] emem1 [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Router model: fixed one-cycle response, r_data zero when idle, flushed by clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            rmem0[k] <= 32'h1000_0000 + k;
            rmem1[k] <= 32'h2000_0000 + k;
         end
         out_if[0].r_valid <= 1'b0;
         out_if[1].r_valid <= 1'b0;
         out_if[0].r_data  <= '0;
         out_if[1].r_data  <= '0;
      end else begin
         out_if[0].r_valid <= !clear && out_if[0].req && out_if[0].gnt;
         out_if[1].r_valid <= !clear && out_if[0].req && out_if[0].gnt;
         out_if[0].r_data  <= '0;
         out_if[1].r_data  <= '0;
         if (!clear && out_if[0].req && out_if[0].gnt) begin
            if (out_if[0].wen) begin
               out_if[0].r_data <= rmem0[out_if[0].add[5:2]];
               out_if[1].r_data <= rmem1[out_if[1].add[5:2]];
            end else begin
               rmem0[out_if[0].add[5:2]] <= out_if[0].data;
               rmem1[out_if[1].add[5:2]] <= out_if[1].data;
            end
         end
      end
   end

   // Monitor: compares pops against the scoreboard, then records accepted requests.
   initial begin : mon
      exp_t e;
      logic [3:0] a0, a1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
               emem0[k] = 32'h1000_0000 + k;
               emem1[k] = 32'h2000_0000 + k;
            end
            sb.delete();
         end else if (clear) begin
            sb.delete();
         end else begin
            if (in_if[0].r_valid && in_if[0].r_ready && in_if[1].r_ready) begin
               if (sb.size() == 0) begin
                  chk("spurious_rsp", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_lane0", in_if[0].r_data, e.d0);
                  chk("rsp_lane1", in_if[1].r_data, e.d1);
                  if (lat_chk) chk("rsp_latency", cyc, e.t + LAT);
                  last0 = in_if[0].r_data;
               end
            end
            if (in_if[0].req && in_if[0].gnt) begin
               a0 = in_if[0].add[5:2];
               a1 = in_if[1].add[5:2];
               if (in_if[0].wen) begin
                  e.d0 = emem0[a0];
                  e.d1 = emem1[a1];
               end else begin
                  e.d0 = '0;
                  e.d1 = '0;
                  emem0[a0] = in_if[0].data;
                  emem1[a1] = in_if[1].data;
               end
               e.t = cyc;
               sb.push_back(e);
            end
         end
      end
   end

   task automatic set_req(input bit r, input bit rd, input logic [31:0] a,
                          input logic [31:0] d0, input logic [31:0] d1);
      in_if[0].req = r;  in_if[1].req = r;
      in_if[0].wen = rd; in_if[1].wen = rd;
      in_if[0].add = a;  in_if[1].add = a;
      in_if[0].data = d0;
      in_if[1].data = d1;
   endtask

   task automatic set_rdy(input bit r);
      in_if[0].r_ready = r;
      in_if[1].r_ready = r;
   endtask

   task automatic set_ogt(input bit g);
      out_if[0].gnt = g;
      out_if[1].gnt = g;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() != 0; k++) next_cyc();
      chk("drain_empty", sb.size(), 0);
      @(negedge clk);
      chk("idle_rvalid", in_if[0].r_valid, 1'b0);
      next_cyc();
   endtask

   initial begin : stim
      int granted;
      logic [31:0] held;
      for (int i = 0; i < NB_CHAN; i++) begin
         if (i == 0) begin
            in_if[0].be = '1; in_if[0].user = '0; in_if[0].id = '0; in_if[0].ecc = '0;
            in_if[0].ereq = 1'b0; in_if[0].r_eready = 1'b1;
            out_if[0].egnt = 1'b1; out_if[0].r_user = '0; out_if[0].r_id = '0;
            out_if[0].r_opc = 1'b0; out_if[0].r_ecc = '0; out_if[0].r_evalid = 1'b0;
         end else begin
            in_if[1].be = '1; in_if[1].user = '0; in_if[1].id = '0; in_if[1].ecc = '0;
            in_if[1].ereq = 1'b0; in_if[1].r_eready = 1'b1;
            out_if[1].egnt = 1'b1; out_if[1].r_user = '0; out_if[1].r_id = '0;
            out_if[1].r_opc = 1'b0; out_if[1].r_ecc = '0; out_if[1].r_evalid = 1'b0;
         end
      end
      set_req(1'b0, 1'b1, '0, '0, '0);
      set_rdy(1'b1);
      set_ogt(1'b1);

      // Reset values
      @(negedge clk);
      chk("rst_rvalid", in_if[0].r_valid, 1'b0);
      chk("rst_rdata0", in_if[0].r_data, 32'h0);
      chk("rst_rdata1", in_if[1].r_data, 32'h0);
      chk("rst_gnt", in_if[0].gnt, 1'b1);
      chk("rst_count", dut.count_q, 0);
      chk("rst_infl", dut.infl_q, 1'b0);
      next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // Back-to-back reads, full throughput, fixed latency
      lat_chk = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_req(1'b1, 1'b1, 32'(k * 4), '0, '0);
         @(negedge clk);
         chk("bb_gnt", in_if[0].gnt & in_if[1].gnt, 1'b1);
         next_cyc();
      end
      set_req(1'b0, 1'b1, '0, '0, '0);
      drain();
      lat_chk = 1'b0;

      // Response stall: credits exhaust after DEPTH grants
      set_rdy(1'b0);
      granted = 0;
      for (int k = 0; k < 8; k++) begin
         set_req(granted < 5, 1'b1, 32'h20 + 32'(granted * 4), '0, '0);
         @(negedge clk);
         if (in_if[0].req && in_if[0].gnt) granted++;
         next_cyc();
      end
      chk("stall_granted", granted, 3);
      @(negedge clk);
      chk("stall_count", dut.count_q, 3);
      chk("stall_gnt", in_if[0].gnt, 1'b0);
      chk("stall_rvalid", in_if[0].r_valid, 1'b1);
      held = in_if[0].r_data;
      chk("stall_head", held, 32'h1000_0008);
      next_cyc();
      next_cyc();
      @(negedge clk);
      chk("stall_stable", in_if[0].r_data, held);
      next_cyc();
      set_rdy(1'b1);
      for (int k = 0; k < 30 && granted < 5; k++) begin
         set_req(1'b1, 1'b1, 32'h20 + 32'(granted * 4), '0, '0);
         @(negedge clk);
         if (in_if[0].req && in_if[0].gnt) granted++;
         next_cyc();
      end
      chk("release_granted", granted, 5);
      set_req(1'b0, 1'b1, '0, '0, '0);
      drain();

      // Router not granting
      set_ogt(1'b0);
      set_req(1'b1, 1'b1, 32'h30, '0, '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("nogt_gnt", in_if[0].gnt, 1'b0);
         chk("nogt_req_fwd", out_if[0].req, 1'b1);
         chk("nogt_infl", dut.infl_q, 1'b0);
         chk("nogt_count", dut.count_q, 0);
         next_cyc();
      end
      set_req(1'b0, 1'b1, '0, '0, '0);
      set_ogt(1'b1);
      next_cyc();

      // Write then read of the same address
      set_req(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      next_cyc();
      set_req(1'b1, 1'b1, 32'h40, '0, '0);
      next_cyc();
      set_req(1'b0, 1'b1, '0, '0, '0);
      drain();
      chk("wr_rd_data", last0, 32'hDEAD_BEEF);

      // Clear with two queued and one in flight
      set_rdy(1'b0);
      for (int k = 0; k < 3; k++) begin
         set_req(1'b1, 1'b1, 32'h50 + 32'(k * 4), '0, '0);
         next_cyc();
      end
      set_req(1'b0, 1'b1, '0, '0, '0);
      clear = 1'b1;
      @(negedge clk);
      chk("preclr_count", dut.count_q, 2);
      chk("preclr_infl", dut.infl_q, 1'b1);
      next_cyc();
      clear = 1'b0;
      @(negedge clk);
      chk("clr_count", dut.count_q, 0);
      chk("clr_infl", dut.infl_q, 1'b0);
      chk("clr_wrptr", dut.wr_ptr_q, 0);
      chk("clr_rvalid", in_if[0].r_valid, 1'b0);
      chk("clr_rdata", in_if[0].r_data, 32'h0);
      chk("clr_gnt", in_if[0].gnt, 1'b1);
      next_cyc();
      set_rdy(1'b1);
      for (int k = 0; k < 4; k++) next_cyc();
      chk("clr_nothing_left", sb.size(), 0);

      // Pointer wrap with alternating r_ready
      granted = 0;
      for (int k = 0; k < 80 && granted < 10; k++) begin
         set_rdy(k[0]);
         set_req(1'b1, 1'b1, 32'((granted % 16) * 4), '0, '0);
         @(negedge clk);
         if (in_if[0].req && in_if[0].gnt) granted++;
         next_cyc();
      end
      chk("wrap_granted", granted, 10);
      set_req(1'b0, 1'b1, '0, '0, '0);
      set_rdy(1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
